// File: rtl/config_pkg.sv
// Shared opcode definitions and helpers for the configuration byte protocol.
// Imported by both this encoder and the far-end decoder.
package config_pkg;

  localparam logic [7:0] OP_EXT_COUNTER_RX  = 8'hF8;
  localparam logic [7:0] OP_EXT_COUNTER_TX  = 8'hF9;
  localparam logic [7:0] OP_OSC_FREQ        = 8'hFA;
  localparam logic [7:0] OP_ARTHUR          = 8'hFB;
  localparam logic [7:0] OP_CLR_EXT_FLAG_RX = 8'hFC;
  localparam logic [7:0] OP_CLR_EXT_FLAG_TX = 8'hFD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SEND,
    ST_GAP,
    ST_TRAIL
  } tx_state_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] len;
  } op_info_t;

  function automatic op_info_t op_info(input logic [7:0] op);
    op_info_t info;
    info = '{ok: 1'b0, len: 2'd0};
    case (op)
      OP_EXT_COUNTER_RX, OP_EXT_COUNTER_TX: info = '{ok: 1'b1, len: 2'd2};
      OP_OSC_FREQ, OP_ARTHUR:               info = '{ok: 1'b1, len: 2'd1};
      OP_CLR_EXT_FLAG_RX, OP_CLR_EXT_FLAG_TX: info = '{ok: 1'b1, len: 2'd0};
      default:                              info = '{ok: 1'b0, len: 2'd0};
    endcase
    return info;
  endfunction

  // Byte idx of a frame: opcode, then payload MSB first.
  function automatic logic [7:0] frame_byte(input logic [7:0]  op,
                                            input logic [15:0] payload,
                                            input logic [1:0]  len,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    b = op;
    if (idx == 2'd1)
      b = (len == 2'd2) ? payload[15:8] : payload[7:0];
    else if (idx == 2'd2)
      b = payload[7:0];
    return b;
  endfunction

endpackage

// File: rtl/config_tx.sv
// Host-side serialiser: turns one command into a framed byte stream
// (opcode, then payload MSB first) with lead/gap/trail spacing for the decoder.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LEAD  | o_CONFIG high, letting the far-end synchroniser settle
// SEND  | byte presented, waiting for spi_tx_ready
// GAP   | valid low between bytes so each byte gets a fresh edge
// TRAIL | o_CONFIG held after the last byte
module config_tx
  import config_pkg::*;
#(
  parameter int LEAD_CYC  = 4,
  parameter int GAP_CYC   = 2,
  parameter int TRAIL_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [15:0] cmd_payload,
  output logic [7:0]  spi_tx_data,
  output logic        spi_tx_valid,
  input  logic        spi_tx_ready,
  output logic        o_CONFIG,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [7:0] LEAD_LOAD  = 8'(LEAD_CYC - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);
  localparam logic [7:0] TRAIL_LOAD = 8'(TRAIL_CYC - 1);

  tx_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  len_q, len_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] pay_q, pay_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;
  op_info_t    info;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      len_q   <= 2'd0;
      op_q    <= 8'd0;
      pay_q   <= 16'd0;
      data_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      op_q    <= op_d;
      pay_q   <= pay_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    op_d    = op_q;
    pay_d   = pay_q;
    data_d  = data_q;
    err_d   = 1'b0;
    info    = op_info(cmd_opcode);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (info.ok) begin
            op_d    = cmd_opcode;
            pay_d   = cmd_payload;
            len_d   = info.len;
            idx_d   = 2'd0;
            cnt_d   = LEAD_LOAD;
            state_d = ST_LEAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LEAD: begin
        if (cnt_q == 8'd0) begin
          data_d  = frame_byte(op_q, pay_q, len_q, idx_q);
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SEND: begin
        if (spi_tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == len_q) begin
            cnt_d   = TRAIL_LOAD;
            state_d = ST_TRAIL;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          data_d  = frame_byte(op_q, pay_q, len_q, idx_q);
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_TRAIL: begin
        if (cnt_q == 8'd0)
          state_d = ST_IDLE;
        else
          cnt_d = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cmd_ready also gated by rst so nothing is accepted while held in reset.
  assign cmd_ready    = rst && (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign o_CONFIG     = (state_q != ST_IDLE);
  assign spi_tx_valid = (state_q == ST_SEND);
  assign spi_tx_data  = data_q;
  assign cmd_err      = err_q;

endmodule

// File: tb/tb_config_tx.sv
// Directed bench for config_tx: a frame-level reference model checked every
// cycle, plus literal expectations on captured byte sequences and timing.
module tb_config_tx;

  localparam int LEAD  = 4;
  localparam int GAP   = 2;
  localparam int TRAIL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode = 8'h00;
  logic [15:0] cmd_payload = 16'h0000;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_valid;
  logic        spi_tx_ready = 1'b1;
  logic        o_CONFIG;
  logic        busy;
  logic        cmd_err;

  config_tx #(.LEAD_CYC(LEAD), .GAP_CYC(GAP), .TRAIL_CYC(TRAIL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_payload(cmd_payload),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
    .spi_tx_ready(spi_tx_ready),
    .o_CONFIG(o_CONFIG), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: frame = queue of bytes; timing from lead/gap/trail rules.
  logic       m_active = 1'b0;
  logic       m_valid  = 1'b0;
  logic [7:0] m_data   = 8'h00;
  logic       m_err    = 1'b0;
  int         m_wait   = 0;
  int         m_trail  = 0;
  logic [7:0] mq[$];

  always @(posedge clk) begin
    if (!rst) begin
      m_active = 1'b0; m_valid = 1'b0; m_data = 8'h00; m_err = 1'b0;
      m_trail = 0; m_wait = 0; mq.delete();
    end else begin
      m_err = 1'b0;
      if (!m_active) begin
        if (cmd_valid) begin
          mq.delete();
          case (cmd_opcode)
            8'hF8, 8'hF9: mq = '{cmd_opcode, cmd_payload[15:8], cmd_payload[7:0]};
            8'hFA, 8'hFB: mq = '{cmd_opcode, cmd_payload[7:0]};
            8'hFC, 8'hFD: mq = '{cmd_opcode};
            default:      m_err = 1'b1;
          endcase
          if (!m_err) begin
            m_active = 1'b1; m_wait = LEAD; m_trail = 0;
          end
        end
      end else if (m_valid) begin
        if (spi_tx_ready) begin
          void'(mq.pop_front());
          m_valid = 1'b0;
          if (mq.size() == 0) m_trail = TRAIL;
          else m_wait = GAP;
        end
      end else if (m_trail > 0) begin
        m_trail--;
        if (m_trail == 0) m_active = 1'b0;
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_data  = mq[0];
        end
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_config", o_CONFIG, m_active);
      check("model_busy", busy, m_active);
      check("model_valid", spi_tx_valid, m_valid);
      check("model_data", spi_tx_data, m_data);
      check("model_err", cmd_err, m_err);
      check("model_ready", cmd_ready, rst && !m_active);
    end
  end

  // Frame observation for literal checks.
  logic [7:0] got[$];
  int runs[$];
  int run = 0, lead = 0, post = 0, err_cnt = 0;
  logic seen_valid = 1'b0;

  always @(negedge clk) begin
    if (spi_tx_valid && spi_tx_ready) begin
      got.push_back(spi_tx_data);
      post = 0;
    end else if (o_CONFIG && !spi_tx_valid) begin
      post++;
    end
    if (spi_tx_valid) run++;
    else if (run > 0) begin runs.push_back(run); run = 0; end
    if (spi_tx_valid) seen_valid = 1'b1;
    if (o_CONFIG && !seen_valid) lead++;
    if (cmd_err) err_cnt++;
  end

  task automatic clear_mon();
    got.delete(); runs.delete();
    run = 0; lead = 0; post = 0; err_cnt = 0; seen_valid = 1'b0;
  endtask

  // Stall responder: ready rises once valid has been high stall_n cycles.
  int stall_n = 0;
  int vc = 0;
  always @(posedge clk) begin
    #1;
    if (spi_tx_valid) vc++; else vc = 0;
    if (stall_n > 0) spi_tx_ready = (vc >= stall_n);
  end

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] pay);
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_payload = pay;
    @(posedge clk); #2;
    cmd_valid = 1'b0; cmd_opcode = 8'h55; cmd_payload = 16'hDEAD;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1'b1; break; end
    end
    check(name, done, 1'b1);
  endtask

  logic [7:0] all_bytes[$];

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_config", o_CONFIG, 1'b0);
    check("reset_data", spi_tx_data, 8'h00);
    check("reset_ready", cmd_ready, 1'b1);

    // F8 with ready tied high
    clear_mon();
    send_cmd(8'hF8, 16'h1234);
    wait_idle("f8_timeout");
    check("f8_count", got.size(), 3);
    if (got.size() == 3) begin
      check("f8_b0", got[0], 8'hF8);
      check("f8_b1", got[1], 8'h12);
      check("f8_b2", got[2], 8'h34);
    end
    check("f8_lead", lead, LEAD);
    check("f8_trail", post, TRAIL);
    check("f8_runs", runs.size(), 3);
    foreach (runs[i]) check("f8_run_width", runs[i], 1);

    // FA with 5-cycle stall per byte
    clear_mon();
    stall_n = 5;
    send_cmd(8'hFA, 16'hAB03);
    wait_idle("fa_timeout");
    stall_n = 0; spi_tx_ready = 1'b1;
    check("fa_count", got.size(), 2);
    if (got.size() == 2) begin
      check("fa_b0", got[0], 8'hFA);
      check("fa_b1", got[1], 8'h03);
    end
    check("fa_runs", runs.size(), 2);
    foreach (runs[i]) check("fa_run_width", runs[i], 5);

    // FC: opcode only
    clear_mon();
    send_cmd(8'hFC, 16'h0000);
    wait_idle("fc_timeout");
    check("fc_count", got.size(), 1);
    if (got.size() == 1) check("fc_b0", got[0], 8'hFC);
    check("fc_trail", post, TRAIL);

    // Unknown opcode
    clear_mon();
    send_cmd(8'h42, 16'h1111);
    repeat (4) @(negedge clk);
    check("bad_err_pulses", err_cnt, 1);
    check("bad_lead", lead, 0);
    check("bad_count", got.size(), 0);
    check("bad_ready", cmd_ready, 1'b1);

    // Loopback-style sequence decoded bench-side
    clear_mon();
    send_cmd(8'hF9, 16'hBEEF); wait_idle("lb1_timeout");
    send_cmd(8'hFB, 16'h000A); wait_idle("lb2_timeout");
    send_cmd(8'hFD, 16'h0000); wait_idle("lb3_timeout");
    all_bytes = got;
    check("lb_count", all_bytes.size(), 6);
    if (all_bytes.size() == 6) begin
      check("lb_tx_value", {all_bytes[1], all_bytes[2]}, 16'hBEEF);
      check("lb_arthur", all_bytes[4][3:0], 4'hA);
      check("lb_clr_op", all_bytes[5], 8'hFD);
    end

    // Reset while in GAP of an F8 frame
    clear_mon();
    send_cmd(8'hF8, 16'h1234);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (got.size() >= 1) break;
    end
    check("rst_first_byte", got.size(), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("rst_config", o_CONFIG, 1'b0);
    check("rst_valid", spi_tx_valid, 1'b0);
    check("rst_data", spi_tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    check("rst_no_more", got.size(), 1);
    clear_mon();
    send_cmd(8'hF8, 16'h5678);
    wait_idle("post_rst_timeout");
    check("post_rst_count", got.size(), 3);
    if (got.size() == 3) begin
      check("post_rst_b0", got[0], 8'hF8);
      check("post_rst_b1", got[1], 8'h56);
      check("post_rst_b2", got[2], 8'h78);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
